// File: rtl/fp_addsub_seq.sv
// IEEE-754 add/subtract walked through UNPACK/ALIGN/ADD/NORM/ROUND; each state names the data its registers hold.
// done pulses 5 cycles after start is accepted, independent of operands; start is ignored while busy.
module fp_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   sub,
    input  logic [EXP_W+MAN_W:0]   dataa,
    input  logic [EXP_W+MAN_W:0]   datab,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   busy,
    output logic                   done,
    output logic [3:0]             flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int XW = MAN_W + 4;
    localparam int EW = EXP_W + 1;
    localparam int CW = EXP_W + 7;
    localparam logic [EXP_W-1:0] E_ONES = '1;
    localparam logic [W-1:0]     QNAN   = {1'b0, E_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND} state_t;
    state_t state, state_nx;

    logic             a_s, b_s, a_nan, b_nan, a_inf, b_inf, a_big;
    logic [EXP_W-1:0] a_e, b_e, a_ee, b_ee;
    logic [MAN_W-1:0] a_m, b_m;
    logic [MAN_W:0]   a_sig, b_sig;
    logic             sp_hit;
    logic [W-1:0]     sp_res;
    logic [3:0]       sp_flg;

    assign {a_s, a_e, a_m} = dataa;
    assign b_s   = datab[W-1] ^ sub;
    assign b_e   = datab[W-2:MAN_W];
    assign b_m   = datab[MAN_W-1:0];
    assign a_nan = (a_e == E_ONES) && (a_m != '0);
    assign b_nan = (b_e == E_ONES) && (b_m != '0);
    assign a_inf = (a_e == E_ONES) && (a_m == '0);
    assign b_inf = (b_e == E_ONES) && (b_m == '0);
    assign a_ee  = (a_e == '0) ? EXP_W'(1) : a_e;
    assign b_ee  = (b_e == '0) ? EXP_W'(1) : b_e;
    assign a_sig = {a_e != '0, a_m};
    assign b_sig = {b_e != '0, b_m};
    assign a_big = {a_ee, a_sig} >= {b_ee, b_sig};

    always_comb begin
        sp_hit = 1'b1;
        sp_res = QNAN;
        sp_flg = 4'b0000;
        if (a_nan || b_nan)
            sp_flg = {(a_nan && !a_m[MAN_W-1]) || (b_nan && !b_m[MAN_W-1]), 3'b000};
        else if (a_inf && b_inf && (a_s != b_s))
            sp_flg = 4'b1000;
        else if (a_inf)
            sp_res = {a_s, E_ONES, {MAN_W{1'b0}}};
        else if (b_inf)
            sp_res = {b_s, E_ONES, {MAN_W{1'b0}}};
        else
            sp_hit = 1'b0;
    end

    // UNPACK: operands sorted by magnitude; specials and zero sign are kept to the end
    logic             u_sp_hit, u_zs, u_sb, u_ss;
    logic [W-1:0]     u_sp_res;
    logic [3:0]       u_sp_flg;
    logic [EXP_W-1:0] u_eb, u_es;
    logic [MAN_W:0]   u_mb, u_ms;

    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            u_sp_hit <= sp_hit;
            u_sp_res <= sp_res;
            u_sp_flg <= sp_flg;
            u_zs     <= a_s & b_s;
            u_sb     <= a_big ? a_s : b_s;
            u_ss     <= a_big ? b_s : a_s;
            u_eb     <= a_big ? a_ee : b_ee;
            u_es     <= a_big ? b_ee : a_ee;
            u_mb     <= a_big ? a_sig : b_sig;
            u_ms     <= a_big ? b_sig : a_sig;
        end
    end

    logic [EXP_W-1:0] diff;
    logic [XW-1:0]    ext_s, al_s;
    logic             l_sub;
    logic [EXP_W-1:0] l_e;
    logic [XW-1:0]    l_xb, l_xs;

    assign diff  = u_eb - u_es;
    assign ext_s = {u_ms, 3'b000};

    always_comb begin
        if (CW'(diff) >= CW'(XW - 1))
            al_s = {{(XW-1){1'b0}}, |ext_s};
        else
            al_s = (ext_s >> diff) | {{(XW-1){1'b0}}, |(ext_s & ~({XW{1'b1}} << diff))};
    end

    always_ff @(posedge clk) begin
        l_sub <= u_sb ^ u_ss;
        l_e   <= u_eb;
        l_xb  <= {u_mb, 3'b000};
        l_xs  <= al_s;
    end

    logic [XW:0]      sum_c, d_sum;
    logic [EXP_W-1:0] d_e;
    logic             d_s;

    assign sum_c = l_sub ? ({1'b0, l_xb} - {1'b0, l_xs}) : ({1'b0, l_xb} + {1'b0, l_xs});

    always_ff @(posedge clk) begin
        d_sum <= sum_c;
        d_e   <= l_e;
        d_s   <= (sum_c == '0) ? u_zs : u_sb;
    end

    // NORM: the left shift stops at exponent 1, leaving a denormal; n_e is the encoded exponent
    logic [CW-1:0] lzc, room, sh;
    logic [XW-1:0] nrm_m, n_m;
    logic [EW-1:0] nrm_e, n_e;
    logic          n_s;

    always_comb begin
        lzc = CW'(XW);
        for (int i = 0; i < XW; i++)
            if (d_sum[i]) lzc = CW'(XW - 1 - i);
        room = CW'(d_e) - CW'(1);
        sh   = (lzc < room) ? lzc : room;
        if (d_sum[XW]) begin
            nrm_m = d_sum[XW:1] | XW'(d_sum[0]);
            nrm_e = {1'b0, d_e} + EW'(1);
        end else begin
            nrm_m = d_sum[XW-1:0] << sh;
            nrm_e = nrm_m[XW-1] ? EW'(CW'(d_e) - sh) : '0;
        end
    end

    always_ff @(posedge clk) begin
        n_m <= nrm_m;
        n_e <= nrm_e;
        n_s <= d_s;
    end

    logic [MAN_W+1:0] rsig;
    logic [EW-1:0]    re;
    logic             inx;
    logic [W-1:0]     rnd_res;
    logic [3:0]       rnd_flg;

    always_comb begin
        inx  = |n_m[2:0];
        rsig = {1'b0, n_m[XW-1:3]} + (MAN_W+2)'(n_m[2] & (n_m[1] | n_m[0] | n_m[3]));
        if (rsig[MAN_W+1])
            re = n_e + EW'(1);
        else if (rsig[MAN_W])
            re = (n_e == '0) ? EW'(1) : n_e;
        else
            re = '0;
        rnd_res = {n_s, re[EXP_W-1:0], rsig[MAN_W-1:0]};
        rnd_flg = {2'b00, (re == '0) && inx, inx};
        if (re >= {1'b0, E_ONES}) begin
            rnd_res = {n_s, E_ONES, {MAN_W{1'b0}}};
            rnd_flg = 4'b0101;
        end
        if (u_sp_hit) begin
            rnd_res = u_sp_res;
            rnd_flg = u_sp_flg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
            flags  <= '0;
        end else if (state == NORM) begin
            result <= rnd_res;
            flags  <= rnd_flg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = UNPACK;
            UNPACK:  state_nx = ALIGN;
            ALIGN:   state_nx = ADD;
            ADD:     state_nx = NORM;
            NORM:    state_nx = ROUND;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == ROUND);
    end
endmodule
